sim_watchdog_ctrl: RTL and testbench



---
 rtl/sim_watchdog_ctrl_if.sv | 60 ++++++
 rtl/sim_watchdog_ctrl.sv | 151 +++++++++++++++
 tb/tb_sim_watchdog_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/sim_watchdog_ctrl_if.sv
// ---------------------------------------------------------------------------------------------
// sim_watchdog_ctrl_if
//
// Purpose: bundles the control inputs and status outputs of sim_watchdog_ctrl so the
//          simulation top can hand one connection to the watchdog.
//
// Signals:
//   limit        [31:0]      cycle budget, quasi-static, sampled once after reset (0 = off)
//   enable                   count-down qualifier, low holds the counter
//   heartbeat                progress pulse, reloads the budget
//   clear                    re-arm after expiry, also reloads while running
//   running                  watchdog is counting (state RUN)
//   warn                     budget nearly exhausted
//   expired                  sticky timeout flag
//   remaining    [CNT_W-1:0] budget left
//   expire_count [15:0]      expiries since reset, saturating
//
// Modports:
//   master - the side that drives limit/enable/heartbeat/clear (testbench / sim top)
//   slave  - the watchdog itself
// ---------------------------------------------------------------------------------------------
interface sim_watchdog_ctrl_if #(
    parameter int unsigned CNT_W = 32
) ();

    logic [31:0]      limit;
    logic             enable;
    logic             heartbeat;
    logic             clear;
    logic             running;
    logic             warn;
    logic             expired;
    logic [CNT_W-1:0] remaining;
    logic [15:0]      expire_count;

    modport master (
        output limit,
        output enable,
        output heartbeat,
        output clear,
        input  running,
        input  warn,
        input  expired,
        input  remaining,
        input  expire_count
    );

    modport slave (
        input  limit,
        input  enable,
        input  heartbeat,
        input  clear,
        output running,
        output warn,
        output expired,
        output remaining,
        output expire_count
    );

endinterface

// File: rtl/sim_watchdog_ctrl.sv
// ---------------------------------------------------------------------------------------------
// sim_watchdog_ctrl
//
// Purpose: simulation run-control watchdog. Loads a cycle budget once after reset and counts
//          it down while enable is high; every heartbeat (or clear) reloads it. Running out of
//          budget raises a sticky expired flag and bumps a saturating expiry counter. A budget
//          of zero parks the block in a terminal disabled state, so leaving it in a
//          synthesised netlist with limit tied to 0 is harmless.
//
// Ports:
//   clk   input   system clock
//   rstn  input   asynchronous active-low reset
//   bus   slave   sim_watchdog_ctrl_if: limit/enable/heartbeat/clear in,
//                 running/warn/expired/remaining/expire_count out (all registered)
//
// Parameters:
//   WARN_CYCLES  warn asserts while running with remaining <= WARN_CYCLES
//   CNT_W        counter width, must be >= 32; limit is zero-extended to it
//
// Optional feature (macro SIM_WATCHDOG_FINISH_EN, ignored when SYNTHESIS is defined):
//   on the RUN->EXPIRED transition print a message with the budget and stop the simulation
//   with $fatal. Register behaviour is identical with or without the macro.
// ---------------------------------------------------------------------------------------------
module sim_watchdog_ctrl #(
    parameter int unsigned WARN_CYCLES = 1024,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                clk,
    input  logic                rstn,
    sim_watchdog_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        StInit     = 2'd0,
        StRun      = 2'd1,
        StExpired  = 2'd2,
        StDisabled = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
    localparam logic [CNT_W-1:0] WarnThr = CNT_W'(WARN_CYCLES);

    state_e           state_q, state_d;
    logic [31:0]      limit_q, limit_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             expired_q, expired_d;
    logic [15:0]      expire_count_q, expire_count_d;
    logic             running_q, running_d;
    logic             warn_q, warn_d;

    // Next-state logic. Outputs are derived from the next-state values so that every output
    // flop agrees with the state it is registered alongside.
    always_comb begin
        state_d        = state_q;
        limit_d        = limit_q;
        remaining_d    = remaining_q;
        expired_d      = expired_q;
        expire_count_d = expire_count_q;

        unique case (state_q)
            StInit: begin
                limit_d = bus.limit;
                if (bus.limit == 32'd0) begin
                    state_d = StDisabled;
                end else begin
                    state_d     = StRun;
                    remaining_d = CNT_W'(bus.limit);
                end
            end

            StRun: begin
                // A reload wins over the final decrement, so a heartbeat on the last cycle
                // still rescues the run.
                if (bus.clear || bus.heartbeat) begin
                    remaining_d = CNT_W'(limit_q);
                end else if (bus.enable && (remaining_q == CntOne)) begin
                    remaining_d = '0;
                    state_d     = StExpired;
                    expired_d   = 1'b1;
                    if (expire_count_q != 16'hFFFF) begin
                        expire_count_d = expire_count_q + 16'd1;
                    end
                end else if (bus.enable) begin
                    remaining_d = remaining_q - CntOne;
                end
            end

            StExpired: begin
                // Only clear re-arms; heartbeat and enable are deliberately ignored here.
                if (bus.clear) begin
                    remaining_d = CNT_W'(limit_q);
                    expired_d   = 1'b0;
                    state_d     = StRun;
                end
            end

            StDisabled: begin
                remaining_d = '0;
                expired_d   = 1'b0;
            end

            default: begin
                state_d = StInit;
            end
        endcase

        running_d = (state_d == StRun);
        warn_d    = running_d && (remaining_d <= WarnThr);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= StInit;
            limit_q        <= 32'd0;
            remaining_q    <= '0;
            expired_q      <= 1'b0;
            expire_count_q <= 16'd0;
            running_q      <= 1'b0;
            warn_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            limit_q        <= limit_d;
            remaining_q    <= remaining_d;
            expired_q      <= expired_d;
            expire_count_q <= expire_count_d;
            running_q      <= running_d;
            warn_q         <= warn_d;
        end
    end

    assign bus.running      = running_q;
    assign bus.warn         = warn_q;
    assign bus.expired      = expired_q;
    assign bus.remaining    = remaining_q;
    assign bus.expire_count = expire_count_q;

`ifdef SIM_WATCHDOG_FINISH_EN
`ifndef SYNTHESIS
    // Fires on the same edge that registers the expiry, after which the run is over.
    always_ff @(posedge clk) begin
        if (rstn && (state_q == StRun) && (state_d == StExpired)) begin
            $display("watchdog expired: %0d cycles without heartbeat", limit_q);
            $fatal(1);
        end
    end
`endif
`else
    // Expiry is reported only through expired/expire_count.
`endif

endmodule

// File: tb/tb_sim_watchdog_ctrl.sv
module tb_sim_watchdog_ctrl;

    logic clk;
    logic rstn;

    sim_watchdog_ctrl_if #(.CNT_W(32)) wd_if ();

    sim_watchdog_ctrl #(
        .WARN_CYCLES(4),
        .CNT_W      (32)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (wd_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       name;
        logic [31:0] rem;
        logic        run;
        logic        warn;
        logic        exp;
        logic [15:0] ecnt;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   vecs  = 0;
    int   fails = 0;

    // Monitor: after each rising edge, compare every expectation queued for this edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                vecs++;
                if (e.cyc < cyc) begin
                    fails++;
                    $display("FAIL %s: sample for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
                end else if ({wd_if.remaining, wd_if.running, wd_if.warn, wd_if.expired,
                              wd_if.expire_count} !== {e.rem, e.run, e.warn, e.exp, e.ecnt}) begin
                    fails++;
                    $display("FAIL %s @cyc %0d: got rem=%0d run=%b warn=%b exp=%b cnt=%0d, want rem=%0d run=%b warn=%b exp=%b cnt=%0d",
                             e.name, cyc, wd_if.remaining, wd_if.running, wd_if.warn,
                             wd_if.expired, wd_if.expire_count, e.rem, e.run, e.warn, e.exp,
                             e.ecnt);
                end
            end
        end
    end

    // All stimulus tasks start and end at a falling edge.
    task automatic expect_next(input string nm, input logic [31:0] rem, input logic run,
                               input logic w, input logic e, input logic [15:0] c);
        exp_t x;
        x.cyc  = cyc + 1;
        x.name = nm;
        x.rem  = rem;
        x.run  = run;
        x.warn = w;
        x.exp  = e;
        x.ecnt = c;
        q.push_back(x);
    endtask

    task automatic step(input logic en, input logic hb, input logic clr, input string nm,
                        input logic [31:0] rem, input logic run, input logic w, input logic e,
                        input logic [15:0] c);
        wd_if.enable    = en;
        wd_if.heartbeat = hb;
        wd_if.clear     = clr;
        expect_next(nm, rem, run, w, e, c);
        @(negedge clk);
    endtask

    // Reset held across one rising edge (checked all-zero), released at the next falling edge.
    task automatic do_reset(input logic [31:0] lim);
        rstn            = 1'b0;
        wd_if.limit     = lim;
        wd_if.enable    = 1'b0;
        wd_if.heartbeat = 1'b0;
        wd_if.clear     = 1'b0;
        expect_next("reset", 32'd0, 1'b0, 1'b0, 1'b0, 16'd0);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        rstn            = 1'b0;
        wd_if.limit     = 32'd0;
        wd_if.enable    = 1'b0;
        wd_if.heartbeat = 1'b0;
        wd_if.clear     = 1'b0;

        // A: limit=5 counts 5,4,3,2,1 then expires on the 5th RUN edge.
        do_reset(32'd5);
        step(1, 0, 0, "A init",   32'd5, 1, 0, 0, 16'd0);
        step(1, 0, 0, "A dec4",   32'd4, 1, 1, 0, 16'd0);
        step(1, 0, 0, "A dec3",   32'd3, 1, 1, 0, 16'd0);
        step(1, 0, 0, "A dec2",   32'd2, 1, 1, 0, 16'd0);
        step(1, 0, 0, "A dec1",   32'd1, 1, 1, 0, 16'd0);
        step(1, 0, 0, "A expire", 32'd0, 0, 0, 1, 16'd1);
        step(1, 0, 0, "A sticky", 32'd0, 0, 0, 1, 16'd1);

        // B: limit=0 disables; every input ignored.
        do_reset(32'd0);
        step(1, 1, 1, "B init", 32'd0, 0, 0, 0, 16'd0);
        for (int i = 0; i < 100; i++) begin
            step(i[0], i[1], i[2], "B disabled", 32'd0, 0, 0, 0, 16'd0);
        end

        // C: limit=10, warn from remaining<=4, heartbeat at 3 reloads and drops warn.
        do_reset(32'd10);
        step(1, 0, 0, "C init", 32'd10, 1, 0, 0, 16'd0);
        for (int i = 1; i <= 7; i++) begin
            step(1, 0, 0, "C dec", 32'(10 - i), 1, ((10 - i) <= 4), 0, 16'd0);
        end
        step(1, 1, 0, "C hb reload", 32'd10, 1, 0, 0, 16'd0);
        step(0, 0, 0, "C hold",      32'd10, 1, 0, 0, 16'd0);

        // D: limit=4, reload on the final-decrement cycle prevents expiry.
        do_reset(32'd4);
        step(1, 0, 0, "D init",     32'd4, 1, 1, 0, 16'd0);
        step(1, 0, 0, "D dec3",     32'd3, 1, 1, 0, 16'd0);
        step(1, 0, 0, "D dec2",     32'd2, 1, 1, 0, 16'd0);
        step(1, 0, 0, "D dec1",     32'd1, 1, 1, 0, 16'd0);
        step(1, 1, 0, "D hb final", 32'd4, 1, 1, 0, 16'd0);
        step(1, 0, 0, "D dec3b",    32'd3, 1, 1, 0, 16'd0);
        step(1, 1, 1, "D hb+clr",   32'd4, 1, 1, 0, 16'd0);
        step(1, 0, 0, "D dec3c",    32'd3, 1, 1, 0, 16'd0);
        step(1, 0, 0, "D dec2c",    32'd2, 1, 1, 0, 16'd0);
        step(1, 0, 0, "D dec1c",    32'd1, 1, 1, 0, 16'd0);
        step(1, 0, 1, "D clr final", 32'd4, 1, 1, 0, 16'd0);
        step(1, 0, 0, "D dec after", 32'd3, 1, 1, 0, 16'd0);

        // E: limit=2 expiry, heartbeat ignored while expired, clear re-arms, second expiry.
        do_reset(32'd2);
        step(1, 0, 0, "E init",    32'd2, 1, 1, 0, 16'd0);
        step(1, 0, 0, "E dec1",    32'd1, 1, 1, 0, 16'd0);
        step(1, 0, 0, "E expire",  32'd0, 0, 0, 1, 16'd1);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, "E ignore", 32'd0, 0, 0, 1, 16'd1);
        end
        step(0, 0, 1, "E clear",   32'd2, 1, 1, 0, 16'd1);
        step(1, 0, 0, "E dec1b",   32'd1, 1, 1, 0, 16'd1);
        step(1, 0, 0, "E expire2", 32'd0, 0, 0, 1, 16'd2);
        step(0, 0, 1, "E clear2",  32'd2, 1, 1, 0, 16'd2);

        // F: reset clears expire_count; limit changes after INIT are ignored; mid-run reset
        // at remaining=7 re-latches a new limit.
        do_reset(32'd8);
        step(1, 0, 0, "F init",  32'd8, 1, 0, 0, 16'd0);
        step(1, 0, 0, "F dec7",  32'd7, 1, 0, 0, 16'd0);
        wd_if.limit = 32'd3;
        step(0, 0, 0, "F hold",       32'd7, 1, 0, 0, 16'd0);
        step(0, 1, 0, "F late limit", 32'd8, 1, 0, 0, 16'd0);
        step(1, 0, 0, "F dec7b",      32'd7, 1, 0, 0, 16'd0);
        do_reset(32'd20);
        step(1, 0, 0, "F init20", 32'd20, 1, 0, 0, 16'd0);
        step(1, 0, 0, "F dec19",  32'd19, 1, 0, 0, 16'd0);

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            $display("FAIL drain: %0d expectations never sampled, want 0", q.size());
            fails += q.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
